// File: rtl/wdt_multi_channel_pkg.sv
// Shared types and default timing constants for the multi-channel watchdog.
// Also holds the parameter legality rule used at elaboration.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WARN = 2'd2,
    TRIP = 2'd3
  } wdt_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TIMEOUT     = 1000;
  localparam int DEF_WARN_MARGIN = 100;
  localparam int DEF_WINDOW_MIN  = 50;

  // The warning point and the window must both sit inside the counting range.
  function automatic bit wdt_params_legal(input int numCh, input int cntW, input int timeout,
                                          input int warnMargin, input int windowMin);
    longint lim;
    lim = (longint'(1) << cntW) - 1;
    return (numCh >= 1) && (cntW >= 2) && (cntW <= 62) &&
           (timeout >= 2) && (longint'(timeout) <= lim) &&
           (warnMargin >= 1) && (warnMargin <= timeout - 1) &&
           (windowMin >= 0) && (windowMin < timeout - warnMargin);
  endfunction

endpackage

// File: rtl/wdt_multi_channel_if.sv
// Control and status bundle between the watchdog and its host logic.
interface wdt_multi_channel_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] heartbeat;
  logic [NUM_CH-1:0] clear;
  logic              force_reset;
  logic              window_en;
  logic [NUM_CH-1:0] warning;
  logic [NUM_CH-1:0] triggered;
  logic [NUM_CH-1:0] early_kick;
  logic              trip_pulse;
  logic              sys_reset_req;

  modport master (
    output enable, heartbeat, clear, force_reset, window_en,
    input  warning, triggered, early_kick, trip_pulse, sys_reset_req
  );

  modport slave (
    input  enable, heartbeat, clear, force_reset, window_en,
    output warning, triggered, early_kick, trip_pulse, sys_reset_req
  );
endinterface

// File: rtl/wdt_multi_channel_channel.sv
// One watchdog channel: IDLE/RUN/WARN/TRIP state machine, heartbeat counter
// and sticky trip flags, all registered.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int WARN_MARGIN = DEF_WARN_MARGIN,
  parameter int WINDOW_MIN  = DEF_WINDOW_MIN
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_enable,
  input  logic i_heartbeat,
  input  logic i_clear,
  input  logic i_force,
  input  logic i_window_en,
  output logic o_warning,
  output logic o_triggered,
  output logic o_early_kick
);

  localparam logic [CNT_W-1:0] WARN_AT = CNT_W'(TIMEOUT - WARN_MARGIN - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WIN_MIN = CNT_W'(WINDOW_MIN);

  wdt_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_warn;
  logic             r_trig;
  logic             r_early;
  logic             w_earlyHit;

  assign w_earlyHit = i_window_en && (r_cnt < WIN_MIN);

  // Counter is held on entry to TRIP so it never runs past TIMEOUT-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_warn  <= 1'b0;
      r_trig  <= 1'b0;
      r_early <= 1'b0;
    end else if (i_force && i_enable && (r_state != TRIP)) begin
      r_state <= TRIP;
      r_warn  <= 1'b0;
      r_trig  <= 1'b1;
      r_early <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (i_enable) r_state <= RUN;
        end
        RUN, WARN: begin
          if (!i_enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_warn  <= 1'b0;
          end else if (i_heartbeat) begin
            r_warn <= 1'b0;
            if (w_earlyHit) begin
              r_state <= TRIP;
              r_trig  <= 1'b1;
              r_early <= 1'b1;
            end else begin
              r_state <= RUN;
              r_cnt   <= '0;
            end
          end else if ((r_state == RUN) && (r_cnt == WARN_AT)) begin
            r_state <= WARN;
            r_cnt   <= r_cnt + 1'b1;
            r_warn  <= 1'b1;
          end else if ((r_state == WARN) && (r_cnt == LAST)) begin
            r_state <= TRIP;
            r_warn  <= 1'b0;
            r_trig  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TRIP: begin
          // A simultaneous force on an enabled channel keeps it tripped.
          if (i_clear && !(i_force && i_enable)) begin
            r_state <= i_enable ? RUN : IDLE;
            r_cnt   <= '0;
            r_trig  <= 1'b0;
            r_early <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_warning    = r_warn;
  assign o_triggered  = r_trig;
  assign o_early_kick = r_early;

  a_trigSticky: assert property (@(posedge clk) disable iff (!rstn)
    (r_trig && !i_clear) |=> r_trig);
  a_noOverflow: assert property (@(posedge clk) disable iff (!rstn) r_cnt <= LAST);

  c_idle: cover property (@(posedge clk) disable iff (!rstn) r_state == IDLE);
  c_run:  cover property (@(posedge clk) disable iff (!rstn) r_state == RUN);
  c_warn: cover property (@(posedge clk) disable iff (!rstn) r_state == WARN);
  c_trip: cover property (@(posedge clk) disable iff (!rstn) r_state == TRIP);

endmodule

// File: rtl/wdt_multi_channel.sv
// Multi-channel watchdog top: per-channel timers plus trip aggregation into
// a single registered system reset request and a one-cycle new-trip pulse.
module wdt_multi_channel
  import wdt_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int WARN_MARGIN = DEF_WARN_MARGIN,
  parameter int WINDOW_MIN  = DEF_WINDOW_MIN
) (
  input  logic                 clk,
  input  logic                 rstn,
  wdt_multi_channel_if.slave   bus
);

  if (!wdt_params_legal(NUM_CH, CNT_W, TIMEOUT, WARN_MARGIN, WINDOW_MIN)) begin : g_badParams
    $error("wdt_multi_channel: illegal NUM_CH/CNT_W/TIMEOUT/WARN_MARGIN/WINDOW_MIN combination");
  end

  logic [NUM_CH-1:0] w_warn;
  logic [NUM_CH-1:0] w_trig;
  logic [NUM_CH-1:0] w_early;
  logic [NUM_CH-1:0] r_trigDly;
  logic              r_sysReq;
  logic              r_pulse;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wdt_channel #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT),
      .WARN_MARGIN (WARN_MARGIN),
      .WINDOW_MIN  (WINDOW_MIN)
    ) u_channel (
      .clk          (clk),
      .rstn         (rstn),
      .i_enable     (bus.enable[i]),
      .i_heartbeat  (bus.heartbeat[i]),
      .i_clear      (bus.clear[i]),
      .i_force      (bus.force_reset),
      .i_window_en  (bus.window_en),
      .o_warning    (w_warn[i]),
      .o_triggered  (w_trig[i]),
      .o_early_kick (w_early[i])
    );
  end

  // Pulse on any per-channel rising trip, lined up with sys_reset_req rising.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_trigDly <= '0;
      r_sysReq  <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_trigDly <= w_trig;
      r_sysReq  <= |w_trig;
      r_pulse   <= |(w_trig & ~r_trigDly);
    end
  end

  assign bus.warning       = w_warn;
  assign bus.triggered     = w_trig;
  assign bus.early_kick    = w_early;
  assign bus.trip_pulse    = r_pulse;
  assign bus.sys_reset_req = r_sysReq;

endmodule
